// File: rtl/sram_ctl_pkg.sv
// Shared types and default timing for the 93425A bit-slice SRAM controller.
// Optional feature macro: SRAM_CTL_PARITY_EN (adds a parity slice and perr output).
package sram_ctl_pkg;
    localparam int AW         = 10;
    localparam int DEF_DW     = 32;
    localparam int DEF_RD_CYC = 2;
    localparam int DEF_SU_CYC = 1;
    localparam int DEF_WP_CYC = 2;

    typedef enum logic [2:0] {IDLE, RD, WSU, WPUL, WHLD, DONE} state_t;
endpackage

// File: rtl/sram_ctl_parity.sv
// XOR-reduce of a data word; odd=1 when the word has an odd number of ones.
module sram_ctl_parity #(
    parameter int W = 33
) (
    input  logic [W-1:0] d,
    output logic         odd
);
    assign odd = ^d;
endmodule

// File: rtl/sram_ctl.sv
// Sequencer for a bank of 93425A 1Kx1 SRAMs: registered CE_N/WE_N with setup, pulse and hold phases.
// Optional feature macro: SRAM_CTL_PARITY_EN (extra parity slice, perr pulses with ack on bad reads).
module sram_ctl
    import sram_ctl_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int RD_CYC = DEF_RD_CYC,
    parameter int SU_CYC = DEF_SU_CYC,
    parameter int WP_CYC = DEF_WP_CYC
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          busy,
    output logic          ack,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] ram_a,
    output logic          ram_ce_n,
    output logic          ram_we_n,
`ifdef SRAM_CTL_PARITY_EN
    output logic [DW:0]   ram_di,
    input  logic [DW:0]   ram_do,
    output logic          perr
`else
    output logic [DW-1:0] ram_di,
    input  logic [DW-1:0] ram_do
`endif
);
    localparam int CW = 8;

    state_t        state, nxt;
    logic [CW-1:0] cnt;
    logic          last;

`ifdef SRAM_CTL_PARITY_EN
    logic        wpar_odd, rpar_odd;
    logic [DW:0] di_nxt;

    sram_ctl_parity #(.W(DW))   u_gen (.d(wdata),  .odd(wpar_odd));
    sram_ctl_parity #(.W(DW+1)) u_chk (.d(ram_do), .odd(rpar_odd));

    // Stored word plus parity bit always carries an odd number of ones.
    assign di_nxt = {~wpar_odd, wdata};
`else
    logic [DW-1:0] di_nxt;
    assign di_nxt = wdata;
`endif

    always_comb begin
        nxt  = state;
        last = 1'b0;
        case (state)
            IDLE: if (req) nxt = we ? WSU : RD;
            RD: begin
                last = (cnt == CW'(RD_CYC - 1));
                if (last) nxt = DONE;
            end
            WSU:  if (cnt == CW'(SU_CYC - 1)) nxt = WPUL;
            WPUL: if (cnt == CW'(WP_CYC - 1)) nxt = WHLD;
            WHLD: nxt = DONE;
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Strobes are registered from the next state so the RAM never sees decode glitches.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            ram_ce_n <= 1'b1;
            ram_we_n <= 1'b1;
            ram_a    <= '0;
            ram_di   <= '0;
            rdata    <= '0;
        end else begin
            state    <= nxt;
            cnt      <= (nxt != state) ? '0 : cnt + 1'b1;
            ram_ce_n <= !(nxt inside {RD, WSU, WPUL, WHLD});
            ram_we_n <= (nxt != WPUL);
            if (state == IDLE && req) begin
                ram_a  <= addr;
                ram_di <= di_nxt;
            end
            if (state == RD && last) rdata <= ram_do[DW-1:0];
        end
    end

`ifdef SRAM_CTL_PARITY_EN
    always_ff @(posedge clk) begin
        if (!reset_n) perr <= 1'b0;
        else          perr <= (state == RD) && last && !rpar_odd;
    end
`endif

    assign busy = (state != IDLE);
    assign ack  = (state == DONE);
endmodule
